// File: rtl/sram_sp_masked_ext_pkg.sv
// sram_pkg: shared FSM state type, lane-count helper and latency limit for the masked SRAM model
package sram_pkg;
  typedef enum logic [1:0] {CLEAR, IDLE_WAIT, RUN} sram_state_e;
  localparam int SRAM_MAX_READ_LAT = 2;
  function automatic int sram_nlane(input int data_w, input int gran);
    return data_w / gran;
  endfunction
endpackage

// File: rtl/sram_sp_masked_ext_if.sv
// sram_sp_masked_ext_if: single-port RW0 access bus (request from master, read return from slave)
interface sram_sp_masked_ext_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14,
  parameter int NLANE  = 8
);
  logic              en;
  logic              wmode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NLANE-1:0]  wmask;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  modport master (output en, wmode, addr, wdata, wmask, input rdata, rvalid);
  modport slave  (input en, wmode, addr, wdata, wmask, output rdata, rvalid);
endinterface

// File: rtl/sram_sp_masked_ext_rd_pipe.sv
// sram_rd_pipe: delays read data/valid by STAGES cycles; the output holds the last valid beat
module sram_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);
  if (STAGES == 0) begin : g_bypass
    logic [DATA_W-1:0] r_hold;
    // remember the last valid beat so the output is stable between strobes
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_hold <= '0;
      else if (i_vld) r_hold <= i_data;
    assign o_vld  = i_vld;
    assign o_data = i_vld ? i_data : r_hold;
  end else begin : g_pipe
    logic [STAGES-1:0] r_v;
    logic [DATA_W-1:0] r_d [STAGES];
    logic [STAGES-1:0] w_v;
    logic [DATA_W-1:0] w_d [STAGES];
    assign w_v    = STAGES'({r_v, i_vld});
    assign w_d[0] = i_data;
    for (genvar s = 1; s < STAGES; s++) begin : g_link
      assign w_d[s] = r_d[s-1];
    end
    // each stage loads only on a valid beat, so the last stage doubles as the hold register
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_v <= '0;
        for (int s = 0; s < STAGES; s++) r_d[s] <= '0;
      end else begin
        r_v <= w_v;
        for (int s = 0; s < STAGES; s++) if (w_v[s]) r_d[s] <= w_d[s];
      end
    assign o_vld  = r_v[STAGES-1];
    assign o_data = r_d[STAGES-1];
  end
endmodule

// File: rtl/sram_sp_masked_ext.sv
// sram_sp_masked_ext: masked single-port SRAM with post-reset zero-fill; SRAM_OOR_CHECK_EN enables sticky err_oor
module sram_sp_masked_ext import sram_pkg::*; #(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 12288,
  parameter int ADDR_W         = 14,
  parameter int MASK_GRAN      = 8,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 RW0_clk,
  input  logic                 RW0_rst_n,
  sram_sp_masked_ext_if.slave  RW0,
  output logic                 init_done,
  output logic                 err_oor
);
  localparam int NLANE = sram_nlane(DATA_W, MASK_GRAN);
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
  if (READ_LAT < 1 || READ_LAT > SRAM_MAX_READ_LAT) begin : g_bad_lat
    $error("sram_sp_masked_ext: READ_LAT must be 1..%0d", SRAM_MAX_READ_LAT);
  end
  if ((DATA_W % MASK_GRAN) != 0 || (2 ** ADDR_W) < DEPTH) begin : g_bad_geom
    $error("sram_sp_masked_ext: illegal DATA_W/MASK_GRAN/ADDR_W/DEPTH combination");
  end
  logic [DATA_W-1:0] r_mem [DEPTH];
  sram_state_e       r_state, w_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clear, w_run, w_acc, w_in_rng, w_rd, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata, w_rd_data;
  logic [NLANE-1:0]  w_wmask;
  logic [DATA_W-1:0] r_mem_q;
  logic              r_rd_vld, r_rd_oor;
  // control state: only this resets, the array contents never do
  always_ff @(posedge RW0_clk or negedge RW0_rst_n)
    if (!RW0_rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE_WAIT;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  // clear ends after writing the last word; idle-wait lasts one cycle; run is terminal
  always_comb w_next = (r_state == CLEAR) ? ((r_clr_cnt == LP_LAST) ? RUN : CLEAR) : RUN;
  // state decode for the datapath
  always_comb begin
    w_clear = r_state == CLEAR;
    w_run   = r_state == RUN;
  end
  assign init_done = w_run;
  assign w_acc     = w_run & RW0.en;
  assign w_in_rng  = {1'b0, RW0.addr} < LP_DEPTH;
  assign w_rd      = w_acc & ~RW0.wmode;
  // the single write port is shared between the zero-fill sequencer and user writes
  always_comb begin
    w_we    = w_clear | (w_acc & RW0.wmode & w_in_rng);
    w_waddr = w_clear ? r_clr_cnt : RW0.addr;
    w_wdata = w_clear ? '0 : RW0.wdata;
    w_wmask = w_clear ? '1 : RW0.wmask;
  end
  // lane-masked array write
  always_ff @(posedge RW0_clk)
    if (w_we)
      for (int k = 0; k < NLANE; k++)
        if (w_wmask[k]) r_mem[w_waddr][k*MASK_GRAN +: MASK_GRAN] <= w_wdata[k*MASK_GRAN +: MASK_GRAN];
  // synchronous array read, loaded only by an in-range read so it never re-reads a stale address
  always_ff @(posedge RW0_clk)
    if (w_rd & w_in_rng) r_mem_q <= r_mem[RW0.addr];
  // read strobe and out-of-range tag travel alongside the array read
  always_ff @(posedge RW0_clk or negedge RW0_rst_n)
    if (!RW0_rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_oor <= 1'b0;
    end else begin
      r_rd_vld <= w_rd;
      r_rd_oor <= w_rd & ~w_in_rng;
    end
  assign w_rd_data = r_rd_oor ? '0 : r_mem_q;
  sram_rd_pipe #(.DATA_W(DATA_W), .STAGES(READ_LAT - 1)) u_rd_pipe (
    .clk    (RW0_clk),
    .rst_n  (RW0_rst_n),
    .i_vld  (r_rd_vld),
    .i_data (w_rd_data),
    .o_vld  (RW0.rvalid),
    .o_data (RW0.rdata)
  );
`ifdef SRAM_OOR_CHECK_EN
  logic r_err_oor;
  // sticky until reset once any accepted access falls outside the array
  always_ff @(posedge RW0_clk or negedge RW0_rst_n)
    if (!RW0_rst_n) r_err_oor <= 1'b0;
    else if (w_acc & ~w_in_rng) r_err_oor <= 1'b1;
  assign err_oor = r_err_oor;
`ifndef SYNTHESIS
  // report the offending address in simulation
  always @(posedge RW0_clk)
    if (RW0_rst_n && w_acc && !w_in_rng) $error("sram_sp_masked_ext: out-of-range access addr=0x%0h", RW0.addr);
`endif
`else
  assign err_oor = 1'b0;
`endif
endmodule
